// File: rtl/ysyx_23060077_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between the Icache refill
// path and the Dcache/LSU read path; one AR transaction in flight at a time.
module ysyx_23060077_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  ic_valid_i,
    input  logic [ADDR_WIDTH-1:0] ic_addr_i,
    input  logic [LEN_WIDTH-1:0]  ic_len_i,
    output logic                  ic_ready_o,
    output logic [DATA_WIDTH-1:0] ic_data_o,
    output logic                  ic_last_o,

    input  logic                  dc_valid_i,
    input  logic [ADDR_WIDTH-1:0] dc_addr_i,
    input  logic [LEN_WIDTH-1:0]  dc_len_i,
    input  logic [2:0]            dc_size_i,
    output logic                  dc_ready_o,
    output logic [DATA_WIDTH-1:0] dc_data_o,
    output logic                  dc_last_o,

    output logic                  rd_err_o,

    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [LEN_WIDTH-1:0]  arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [3:0]            arid,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;  // 1 = Dcache
    logic                  grant_q, grant_d;            // 1 = Dcache
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [LEN_WIDTH-1:0]  arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [3:0]            arid_q, arid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  err_q, err_d;
    logic                  pick_dc;

    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arid_d       = arid_q;
        arvalid_d    = arvalid_q;
        err_d        = err_q;
        // On a tie the Dcache wins only if the Icache was served last.
        pick_dc      = dc_valid_i & (~ic_valid_i | ~last_grant_q);

        case (state_q)
            IDLE: begin
                if (ic_valid_i | dc_valid_i) begin
                    grant_d   = pick_dc;
                    araddr_d  = pick_dc ? dc_addr_i : ic_addr_i;
                    arlen_d   = pick_dc ? dc_len_i  : ic_len_i;
                    arsize_d  = pick_dc ? dc_size_i : 3'b010;
                    arid_d    = pick_dc ? 4'd1      : 4'd0;
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    arvalid_d    = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (rvalid) begin
                    if (rresp != 2'b00) err_d = 1'b1;
                    if (rlast) begin
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arid_q       <= '0;
            arvalid_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arid_q       <= arid_d;
            arvalid_q    <= arvalid_d;
            err_q        <= err_d;
        end
    end

    logic in_data;
    assign in_data = (state_q == DATA);

    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arid    = arid_q;
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign rready  = in_data;

    // R beats pass straight through to whichever requester owns the burst.
    assign ic_ready_o = in_data & ~grant_q & rvalid;
    assign ic_last_o  = in_data & ~grant_q & rvalid & rlast;
    assign ic_data_o  = (in_data & ~grant_q) ? rdata : '0;
    assign dc_ready_o = in_data & grant_q & rvalid;
    assign dc_last_o  = in_data & grant_q & rvalid & rlast;
    assign dc_data_o  = (in_data & grant_q) ? rdata : '0;

    assign rd_err_o = in_data & rvalid & rlast & (err_q | (rresp != 2'b00));

endmodule

// File: tb/tb_ysyx_23060077_rd_arbiter.sv
// Directed bench for the Icache/Dcache AXI read arbiter: inputs are driven just
// after the falling edge and outputs sampled 1 ns later, away from the rising edge.
module tb_ysyx_23060077_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clock, reset;
    logic          ic_valid_i, dc_valid_i;
    logic [AW-1:0] ic_addr_i, dc_addr_i;
    logic [LW-1:0] ic_len_i, dc_len_i;
    logic [2:0]    dc_size_i;
    logic          ic_ready_o, ic_last_o, dc_ready_o, dc_last_o, rd_err_o;
    logic [DW-1:0] ic_data_o, dc_data_o;
    logic [AW-1:0] araddr;
    logic [LW-1:0] arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arid;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;

    int checks   = 0;
    int failures = 0;

    ysyx_23060077_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock(clock), .reset(reset),
        .ic_valid_i(ic_valid_i), .ic_addr_i(ic_addr_i), .ic_len_i(ic_len_i),
        .ic_ready_o(ic_ready_o), .ic_data_o(ic_data_o), .ic_last_o(ic_last_o),
        .dc_valid_i(dc_valid_i), .dc_addr_i(dc_addr_i), .dc_len_i(dc_len_i),
        .dc_size_i(dc_size_i),
        .dc_ready_o(dc_ready_o), .dc_data_o(dc_data_o), .dc_last_o(dc_last_o),
        .rd_err_o(rd_err_o),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l, input logic [1:0] r);
        rvalid = 1'b1;
        rdata  = d;
        rlast  = l;
        rresp  = r;
    endtask

    task automatic no_beat;
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rdata  = '0;
    endtask

    // Entered 1 ns after a falling edge with arvalid expected high; performs the
    // AR handshake and a single-beat burst, then drops that requester's valid
    // in the cycle after the last beat (the arbiter is IDLE again there).
    task automatic serve_one(input logic is_dc, input logic [AW-1:0] exp_addr,
                             input logic [DW-1:0] d);
        checks++;
        if ({arvalid, arid, araddr} !== {1'b1, (is_dc ? 4'd1 : 4'd0), exp_addr}) begin
            failures++;
            $display("FAIL serve_ar got arvalid=%b arid=%0d araddr=%h exp arvalid=1 arid=%0d araddr=%h",
                     arvalid, arid, araddr, is_dc, exp_addr);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(d, 1'b1, 2'b00);
        #1;
        checks++;
        if ({ic_ready_o, ic_last_o, dc_ready_o, dc_last_o} !== (is_dc ? 4'b0011 : 4'b1100)) begin
            failures++;
            $display("FAIL serve_strobes got=%b exp=%b", {ic_ready_o, ic_last_o, dc_ready_o, dc_last_o},
                     (is_dc ? 4'b0011 : 4'b1100));
        end
        checks++;
        if ((is_dc ? dc_data_o : ic_data_o) !== d) begin
            failures++;
            $display("FAIL serve_data got=%h exp=%h", (is_dc ? dc_data_o : ic_data_o), d);
        end
        tick();
        if (is_dc) dc_valid_i = 1'b0;
        else       ic_valid_i = 1'b0;
        no_beat();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({arvalid, rready, ic_ready_o, ic_last_o, dc_ready_o, dc_last_o, rd_err_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000000",
                     {arvalid, rready, ic_ready_o, ic_last_o, dc_ready_o, dc_last_o, rd_err_o});
        end
        checks++;
        if ({araddr, arlen, arsize, arid} !== 47'd0) begin
            failures++;
            $display("FAIL reset_payload got araddr=%h arlen=%h arsize=%h arid=%h exp all 0",
                     araddr, arlen, arsize, arid);
        end
        checks++;
        if (arburst !== 2'b01) begin
            failures++;
            $display("FAIL reset_arburst got=%b exp=01", arburst);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_ic_only;
        int strobes = 0;
        tick();
        ic_valid_i = 1'b1;
        ic_addr_i  = 32'h3000_0000;
        ic_len_i   = 8'd3;
        #1;
        checks++;
        if (arvalid !== 1'b0) begin
            failures++;
            $display("FAIL ic_req_cycle_arvalid got=%b exp=0", arvalid);
        end
        tick();
        #1;
        checks++;
        if ({arvalid, araddr, arlen, arsize, arid, arburst} !==
            {1'b1, 32'h3000_0000, 8'd3, 3'd2, 4'd0, 2'b01}) begin
            failures++;
            $display("FAIL ic_ar got arvalid=%b araddr=%h arlen=%0d arsize=%0d arid=%0d arburst=%b exp 1 30000000 3 2 0 01",
                     arvalid, araddr, arlen, arsize, arid, arburst);
        end
        arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            arready = 1'b0;
            beat(32'h11 * (i + 1), (i == 3), 2'b00);
            #1;
            if (ic_ready_o) strobes++;
            checks++;
            if ({ic_ready_o, ic_last_o, dc_ready_o, dc_last_o, rready, arvalid} !==
                {1'b1, (i == 3), 4'b0010}) begin
                failures++;
                $display("FAIL ic_beat%0d strobes got=%b exp=%b", i,
                         {ic_ready_o, ic_last_o, dc_ready_o, dc_last_o, rready, arvalid},
                         {1'b1, (i == 3), 4'b0010});
            end
            checks++;
            if (ic_data_o !== 32'h11 * (i + 1)) begin
                failures++;
                $display("FAIL ic_beat%0d data got=%h exp=%h", i, ic_data_o, 32'h11 * (i + 1));
            end
        end
        tick();
        ic_valid_i = 1'b0;
        no_beat();
        #1;
        checks++;
        if ({rready, ic_ready_o, strobes} !== {2'b00, 32'd4}) begin
            failures++;
            $display("FAIL ic_done got rready=%b ic_ready=%b strobes=%0d exp 0 0 4",
                     rready, ic_ready_o, strobes);
        end
    endtask

    task automatic test_tie;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ic_valid_i = 1'b1;
        dc_valid_i = 1'b1;
        ic_addr_i  = 32'h3000_0100;
        ic_len_i   = 8'd0;
        dc_addr_i  = 32'h8000_0040;
        dc_len_i   = 8'd0;
        dc_size_i  = 3'b011;
        tick();
        #1;
        serve_one(1'b0, 32'h3000_0100, 32'hAAAA_0001);
        #1;
        checks++;
        if ({arvalid, rready} !== 2'b00) begin
            failures++;
            $display("FAIL tie_dead_cycle got arvalid=%b rready=%b exp 0 0", arvalid, rready);
        end
        tick();
        #1;
        checks++;
        if ({arsize, arlen} !== {3'b011, 8'd0}) begin
            failures++;
            $display("FAIL tie_dc_payload got arsize=%b arlen=%0d exp 011 0", arsize, arlen);
        end
        serve_one(1'b1, 32'h8000_0040, 32'hBBBB_0002);
        ic_valid_i = 1'b1;
        dc_valid_i = 1'b1;
        tick();
        #1;
        serve_one(1'b0, 32'h3000_0100, 32'hAAAA_0003);
        tick();
        #1;
        serve_one(1'b1, 32'h8000_0040, 32'hBBBB_0004);
    endtask

    task automatic test_arready_stall;
        tick();
        ic_valid_i = 1'b1;
        ic_addr_i  = 32'h3000_0200;
        ic_len_i   = 8'd0;
        tick();
        for (int k = 0; k < 5; k++) begin
            beat(32'hFFFF_FFFF, 1'b1, 2'b00);
            #1;
            checks++;
            if ({arvalid, rready, ic_ready_o, araddr, arlen, arid} !==
                {3'b100, 32'h3000_0200, 8'd0, 4'd0}) begin
                failures++;
                $display("FAIL stall%0d got arvalid=%b rready=%b ic_ready=%b araddr=%h arlen=%0d arid=%0d exp 1 0 0 30000200 0 0",
                         k, arvalid, rready, ic_ready_o, araddr, arlen, arid);
            end
            ic_addr_i = 32'hDEAD_BEEF;
            tick();
        end
        no_beat();
        #1;
        serve_one(1'b0, 32'h3000_0200, 32'h0000_5151);
    endtask

    task automatic test_err;
        tick();
        dc_valid_i = 1'b1;
        dc_addr_i  = 32'h8000_1000;
        dc_len_i   = 8'd1;
        dc_size_i  = 3'b010;
        tick();
        #1;
        checks++;
        if ({arvalid, arid, arlen, arsize} !== {1'b1, 4'd1, 8'd1, 3'b010}) begin
            failures++;
            $display("FAIL err_ar got arvalid=%b arid=%0d arlen=%0d arsize=%b exp 1 1 1 010",
                     arvalid, arid, arlen, arsize);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(32'h55, 1'b0, 2'b10);
        #1;
        checks++;
        if ({dc_ready_o, dc_last_o, rd_err_o} !== 3'b100) begin
            failures++;
            $display("FAIL err_beat0 got=%b exp=100", {dc_ready_o, dc_last_o, rd_err_o});
        end
        tick();
        beat(32'h66, 1'b1, 2'b00);
        #1;
        checks++;
        if ({dc_ready_o, dc_last_o, rd_err_o} !== 3'b111) begin
            failures++;
            $display("FAIL err_last got=%b exp=111", {dc_ready_o, dc_last_o, rd_err_o});
        end
        tick();
        no_beat();
        dc_len_i = 8'd0;
        #1;
        checks++;
        if (rd_err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_after got=%b exp=0", rd_err_o);
        end
        tick();
        #1;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(32'h77, 1'b1, 2'b00);
        #1;
        checks++;
        if ({dc_ready_o, dc_last_o, rd_err_o} !== 3'b110) begin
            failures++;
            $display("FAIL err_clean_next got=%b exp=110", {dc_ready_o, dc_last_o, rd_err_o});
        end
        tick();
        dc_valid_i = 1'b0;
        no_beat();
    endtask

    task automatic test_gap;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int strobes = 0;
        int rready_lo = 0;
        tick();
        ic_valid_i = 1'b1;
        ic_addr_i  = 32'h3000_0300;
        ic_len_i   = 8'd1;
        tick();
        #1;
        arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            arready = 1'b0;
            rvalid  = pat[i];
            rdata   = 32'h100 + i;
            rlast   = (i == 3);
            #1;
            if (ic_ready_o) strobes++;
            if (!rready) rready_lo++;
        end
        checks++;
        if ({strobes, rready_lo} !== {32'd2, 32'd0}) begin
            failures++;
            $display("FAIL gap got strobes=%0d rready_low_cycles=%0d exp 2 0", strobes, rready_lo);
        end
        tick();
        ic_valid_i = 1'b0;
        no_beat();
    endtask

    task automatic test_reset_mid;
        tick();
        ic_valid_i = 1'b1;
        ic_addr_i  = 32'h3000_0400;
        ic_len_i   = 8'd3;
        tick();
        #1;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(32'hA1, 1'b0, 2'b00);
        #1;
        checks++;
        if (ic_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_beat0 got=%b exp=1", ic_ready_o);
        end
        tick();
        reset      = 1'b1;
        ic_valid_i = 1'b0;
        beat(32'hA2, 1'b0, 2'b00);
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({rready, arvalid, ic_ready_o, ic_last_o, dc_ready_o} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_idle got=%b exp=00000", {rready, arvalid, ic_ready_o, ic_last_o, dc_ready_o});
        end
        tick();
        beat(32'hA3, 1'b1, 2'b00);
        #1;
        checks++;
        if ({rready, arvalid, ic_ready_o, ic_last_o} !== 4'b0) begin
            failures++;
            $display("FAIL rstmid_no_fwd got=%b exp=0000", {rready, arvalid, ic_ready_o, ic_last_o});
        end
        tick();
        no_beat();
    endtask

    initial begin
        reset      = 1'b1;
        ic_valid_i = 1'b0;
        dc_valid_i = 1'b0;
        ic_addr_i  = '0;
        dc_addr_i  = '0;
        ic_len_i   = '0;
        dc_len_i   = '0;
        dc_size_i  = '0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rdata      = '0;
        rresp      = 2'b00;
        rlast      = 1'b0;

        test_reset();
        test_ic_only();
        test_tie();
        test_arready_stall();
        test_err();
        test_gap();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_rd_arbiter.md
# ysyx_23060077_rd_arbiter

Shares the single AXI4 read master port between the instruction cache refill path and the data cache/LSU read path. It arbitrates round-robin between the two requesters and issues one AR transaction at a time. It then routes the R beats back to the granted requester. The block sits between the Icache/Dcache miss interfaces and the SoC AXI crossbar.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, beat width
- LEN_WIDTH, 8, AXI burst length width

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ic_valid_i  in  1  Icache read request; held high until its last beat is accepted
- ic_addr_i  in  ADDR_WIDTH  Icache request address
- ic_len_i  in  LEN_WIDTH  Icache burst length (beats minus 1)
- ic_ready_o  out  1  Icache beat strobe: ic_data_o is valid this cycle
- ic_data_o  out  DATA_WIDTH  Icache beat data
- ic_last_o  out  1  Icache final beat strobe
- dc_valid_i  in  1  Dcache request; held high until its last beat is accepted
- dc_addr_i  in  ADDR_WIDTH  Dcache request address
- dc_len_i  in  LEN_WIDTH  Dcache burst length
- dc_size_i  in  3  Dcache AXI size
- dc_ready_o, dc_data_o, dc_last_o  out  1/DATA_WIDTH/1  same as the Icache equivalents
- rd_err_o  out  1  one-cycle pulse when any beat of the granted transfer has rresp != 2'b00
- araddr, arlen, arsize, arburst, arid  out  ADDR_WIDTH/LEN_WIDTH/3/2/4  AXI AR payload
- arvalid  out  1 ; arready  in  1
- rdata  in  DATA_WIDTH ; rresp  in  2 ; rlast  in  1 ; rvalid  in  1 ; rready  out  1

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester not equal to last_grant.
  - On a grant: latch address, length and size into AR registers, set arvalid=1, and go to ADDR.
- Requester payloads:
  - Icache: arsize=3'b010, arid=4'd0.
  - Dcache: arsize=dc_size_i, arid=4'd1.
  - arburst=2'b01 (INCR) always.
- ADDR: hold arvalid and the payload stable until arvalid&arready. Then clear arvalid, update last_grant, and go to DATA.
- DATA:
  - rready=1.
  - The granted requester's ready_o = rvalid, data_o = rdata, last_o = rvalid&rlast. These are combinational pass-through, gated by the grant.
  - The non-granted requester's ready_o/last_o are 0.
  - On rvalid&rlast, return to IDLE.
- Error handling: an error flag accumulates any rresp != 0 during DATA. rd_err_o pulses in the cycle of the last beat if the flag is set or the last beat's rresp != 0. The flag clears when the FSM leaves DATA.
- Valid drops: a requester's valid deasserting after grant does not abort the transfer. Beats are still delivered and the burst completes.
- Beat count: the block does not count beats. Transfer end is defined solely by rlast.

## Timing
- Reset values:
  - State IDLE.
  - arvalid=0, rready=0, all ready/last strobes 0.
  - rd_err_o=0.
  - last_grant=Dcache, so Icache wins the first tie.
  - araddr/arlen/arsize/arid=0, arburst=2'b01.
- Latency:
  - Request in IDLE at cycle N gives arvalid=1 at N+1.
  - A zero-wait slave (arready=1) gives its first R beat accepted at N+2 at the earliest.
- Back-to-back: last beat at cycle M means IDLE at M+1. A pending request is granted at M+1 and arvalid rises at M+2, so there is one dead cycle between transfers.
- AR payload: must not change while arvalid=1 and arready=0.
- R beats with rvalid=0 are ignored; no beat is dropped while in DATA.
- Reset mid-transfer: return to IDLE next edge, arvalid=0, rready=0. Outstanding beats are not forwarded.
- A new valid that rises during ADDR/DATA waits; it is never granted until IDLE.

## Test plan
- Icache-only, ic_addr_i=0x3000_0000, ic_len_i=3, arready=1, 4 beats 0x11..0x44 -> arvalid at N+1 with arid=0, arsize=2, arlen=3; ic_ready_o pulses 4 times with the data in order; ic_last_o pulses only with 0x44; dc_ready_o stays 0.
- Simultaneous requests from reset, both len=0 -> Icache is served first, then Dcache with arsize=dc_size_i and arid=1 at last-beat+2. Repeat the tie -> Icache is served first again, alternating.
- arready held low 5 cycles -> araddr/arlen/arid stable and arvalid high throughout; data phase starts only after the handshake.
- Dcache len=1 with rresp=2'b10 on beat 0 -> rd_err_o pulses exactly once, coincident with dc_last_o.
- Gapped R channel (rvalid 1,0,0,1) during a 2-beat burst -> exactly 2 ready strobes.
- Reset asserted in DATA after 1 of 4 beats -> next cycle IDLE, rready=0, arvalid=0, no further strobes.
